// File: rtl/dot_stream_if.sv
// Streaming interface for dot_stream.
// Input side: in_valid/in_ready handshake carrying signed operands in_a, in_b and an
// in_last flag that marks the final term of a vector.
// Output side: out_valid/out_ready handshake carrying the signed result out_data, the
// term count out_len (saturating at 65535) and the out_ovf range flag.
// Modports: slave = the dot_stream block, master = the producer/consumer driving it.
interface dot_stream_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_a;
  logic signed [IN_WIDTH-1:0]  in_b;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [15:0]                 out_len;
  logic                        out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len, out_ovf
  );
endinterface

// File: rtl/dot_stream.sv
// dot_stream: streaming signed dot-product engine.
// Beats (a, b, last) are accepted on in_valid & in_ready, multiplied in a two-stage
// pipeline and accumulated; the last beat of a vector pushes {sum, length, overflow}
// into a DEPTH-entry result FIFO and restarts the accumulator.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - synchronous, active-high reset
//   stream - dot_stream_if.slave (input beat handshake and result handshake)
// Build option: define DOT_STREAM_SAT_EN to saturate out_data when the sum does not fit
// in OUT_WIDTH; otherwise out_data carries the low OUT_WIDTH bits of the sum.
module dot_stream #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH = 42,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned DEPTH     = 4
) (
  input logic         CLK,
  input logic         RESET,
  dot_stream_if.slave stream
);

  localparam int unsigned ProdW = 2 * IN_WIDTH;
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for count plus the two in-flight last beats.
  localparam int unsigned CntW  = $clog2(DEPTH + 3);
  localparam int unsigned TopW  = ACC_WIDTH - OUT_WIDTH + 1;

  logic                       accept;

  logic                       s1_valid_q;
  logic                       s1_last_q;
  logic signed [IN_WIDTH-1:0] s1_a_q;
  logic signed [IN_WIDTH-1:0] s1_b_q;

  logic                       s2_valid_q;
  logic                       s2_last_q;
  logic signed [ProdW-1:0]    s2_prod_q;
  logic signed [ProdW-1:0]    prod_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [15:0]                 len_q, len_d;
  logic [15:0]                 len_inc;

  logic [TopW-1:0]      sum_top;
  logic                 sum_ovf;
  logic [OUT_WIDTH-1:0] push_data;

  logic [OUT_WIDTH-1:0] mem_data_q [DEPTH];
  logic [15:0]          mem_len_q  [DEPTH];
  logic                 mem_ovf_q  [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push;
  logic                 pop;
  logic                 out_valid;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Reserve a FIFO slot for every last beat still in the pipeline, so a push can never
  // find the FIFO full. Depends on registered state only.
  assign stream.in_ready = (count_q + CntW'(s1_last_q) + CntW'(s2_last_q)) < CntW'(DEPTH);
  assign accept          = stream.in_valid & stream.in_ready;

  // Pipeline control (valid/last are qualified: last is only set alongside valid).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept & stream.in_last;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  // Pipeline data; only meaningful when the matching valid is set.
  assign prod_d = ProdW'(s1_a_q) * ProdW'(s1_b_q);

  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_a_q <= stream.in_a;
      s1_b_q <= stream.in_b;
    end
    if (s1_valid_q) begin
      s2_prod_q <= prod_d;
    end
  end

  // Accumulate; the sum wraps modulo 2^ACC_WIDTH.
  assign prod_ext = ACC_WIDTH'(s2_prod_q);
  assign sum      = acc_q + prod_ext;
  assign len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

  always_comb begin
    acc_d = acc_q;
    len_d = len_q;
    push  = 1'b0;
    if (s2_valid_q) begin
      if (s2_last_q) begin
        push  = 1'b1;
        acc_d = '0;
        len_d = '0;
      end else begin
        acc_d = sum;
        len_d = len_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q <= '0;
      len_q <= '0;
    end else begin
      acc_q <= acc_d;
      len_q <= len_d;
    end
  end

  // The sum fits OUT_WIDTH iff the bits from OUT_WIDTH-1 upward are all equal.
  assign sum_top = sum[ACC_WIDTH-1:OUT_WIDTH-1];
  assign sum_ovf = ~((&sum_top) | ~(|sum_top));

`ifdef DOT_STREAM_SAT_EN
  always_comb begin
    push_data = sum[OUT_WIDTH-1:0];
    if (sum_ovf) begin
      push_data = sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign push_data = sum[OUT_WIDTH-1:0];
`endif

  // Result FIFO.
  assign out_valid = (count_q != '0) & ~RESET;
  assign pop       = out_valid & stream.out_ready;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_len_q[wr_ptr_q]  <= len_inc;
      mem_ovf_q[wr_ptr_q]  <= sum_ovf;
    end
  end

  assign stream.out_valid = out_valid;
  assign stream.out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign stream.out_len   = out_valid ? mem_len_q[rd_ptr_q]  : '0;
  assign stream.out_ovf   = out_valid & mem_ovf_q[rd_ptr_q];

endmodule

// File: doc/dot_stream.md
DOT_STREAM -- requirements
Module: dot_stream

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: signed width of in_a and in_b.
REQ-002 SHALL have parameter ACC_WIDTH, default 42: signed accumulator width.
REQ-003 SHALL have parameter OUT_WIDTH, default 32: signed result width, at most ACC_WIDTH.
REQ-004 SHALL have parameter DEPTH, default 4: result FIFO entries, at least 2.
REQ-005 SHALL have port CLK, input, 1: clock, all logic on the rising edge.
REQ-006 SHALL have port RESET, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-009 SHALL have port in_a, input, IN_WIDTH: signed operand A.
REQ-010 SHALL have port in_b, input, IN_WIDTH: signed operand B.
REQ-011 SHALL have port in_last, input, 1: beat is the final term of the current vector.
REQ-012 SHALL have port out_valid, output, 1: FIFO head result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port out_data, output, OUT_WIDTH: signed dot-product result.
REQ-015 SHALL have port out_len, output, 16: number of terms in the result, saturating at 65535.
REQ-016 SHALL have port out_ovf, output, 1: full-precision sum was outside the OUT_WIDTH signed range.

Function
REQ-017 SHALL accept a beat only on a cycle with in_valid=1 and in_ready=1; other cycles insert pipeline bubbles.
REQ-018 Stage 1 SHALL register a, b, last and valid; stage 2 SHALL register the full-precision signed product (2*IN_WIDTH), last and valid.
REQ-019 When stage 2 is valid and last=0, the block SHALL update acc <= acc + prod and len <= len + 1 (len saturating).
REQ-020 When stage 2 is valid and last=1, the block SHALL push {acc+prod, len+1} into the FIFO and load acc <= 0 and len <= 0 on the same edge.
REQ-021 The accumulator SHALL wrap modulo 2^ACC_WIDTH; prod SHALL be sign-extended before addition.
REQ-022 Latency SHALL be fixed: for a last beat accepted in cycle T with an empty FIFO, out_valid SHALL be 1 in cycle T+3.
REQ-023 in_ready SHALL equal (fifo_count + stage1.last + stage2.last) < DEPTH, registered-state only with no path from in_valid or out_ready.
REQ-024 With out_ready held at 1 and DEPTH >= 4, the block SHALL sustain one beat per cycle, including length-1 vectors.
REQ-025 A FIFO pop SHALL occur when out_valid=1 and out_ready=1; simultaneous push and pop SHALL leave the count unchanged.
REQ-026 out_data, out_len and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_ovf SHALL be computed at push time from the ACC_WIDTH sum against the OUT_WIDTH signed range.
REQ-028 The FIFO SHALL never overflow or underflow; a pop request on an empty FIFO SHALL be ignored.

Reset
REQ-029 RESET SHALL clear the stage valids, acc, len and FIFO pointers/count, discarding partial vectors and queued results, including when RESET is asserted mid-vector.
REQ-030 During and after RESET: out_valid=0, out_data=0, out_len=0, out_ovf=0; in_ready=1 on the first cycle after RESET deasserts.

Configuration
REQ-031 With macro DOT_STREAM_SAT_EN defined, out_data SHALL saturate to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1) when out_ovf=1.
REQ-032 Without DOT_STREAM_SAT_EN, out_data SHALL be the low OUT_WIDTH bits of the sum; out_ovf is reported in both builds.

Verification
REQ-033 Vector (3,4),(−2,5),(7,−1) last on the 3rd beat, out_ready=1 -> one result out_data=-5, out_len=3, out_ovf=0, out_valid exactly 3 cycles after the 3rd accept.
REQ-034 10 back-to-back length-1 vectors a=i, b=2, out_ready=1 -> in_ready stays 1, results 0,2,...,18 in order, one per cycle.
REQ-035 out_ready=0, 6 length-1 vectors offered -> in_ready drops once fifo_count + pending reaches 4; no result is lost; with out_ready=1, 4 results drain and the remaining beats are then accepted.
REQ-036 1000 beats of (32767,32767), last on the final beat, OUT_WIDTH=32 -> out_ovf=1; out_data=2147483647 with DOT_STREAM_SAT_EN, low 32 bits of 1073676289000 without it.
REQ-037 RESET pulsed after 2 beats of a vector, then vector (1,1) last -> out_data=1, out_len=1; no stale result appears.
